// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter with a power-of-two transmit FIFO. Words are
//            accepted over a valid/ready handshake, buffered, and sent as
//            start / data (LSB first) / optional parity / stop bits on an
//            idle-high line. Frames run back-to-back while enable is high and
//            the FIFO holds data.
// Option   : define UART_TX_PARITY_EN to insert a parity bit after the data
//            bits (even parity, or odd when PARITY_ODD=1).
// Ports    : sysclk      system clock, rising edge
//            reset       synchronous active-high reset
//            tx_data     word to transmit
//            tx_valid    tx_data valid this cycle
//            tx_ready    FIFO not full (from registered count)
//            enable      permits starting a new frame
//            fifo_count  words currently buffered
//            busy        a frame is on the line
//            done        one-cycle pulse on the last cycle of the frame
//            UART_TX     serial line, idle high, registered
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        enable,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        done,
  output logic                        UART_TX
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_BW = $clog2(CLKS_PER_BIT);

  localparam logic [c_BW-1:0] c_BAUD_RELOAD = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      c_LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_LAST_STOP   = 4'(STOP_BITS - 1);
  localparam logic [c_AW:0]   c_FULL        = (c_AW + 1)'(FIFO_DEPTH);

  // Elaboration-time parameter legality check.
  if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (STOP_BITS < 1) || (STOP_BITS > 2) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW:0]        r_count;

  // Transmitter
  state_t               r_state;
  logic [c_BW-1:0]      r_baud;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_line;
  logic [DATA_BITS-1:0] w_head;

  // Ready depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign tx_ready    = (r_count != c_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = tx_valid && tx_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_bit_end   = (r_baud == '0);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_LAST_STOP);
  // A pop starts a frame from IDLE or chains directly off the final stop bit.
  assign w_pop       = enable && !w_empty && ((r_state == S_IDLE) || w_last_stop);

  assign fifo_count  = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign UART_TX     = r_tx;

  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  localparam logic c_PAR_INV = (PARITY_ODD != 0);
  logic r_parity;

  // Parity is computed once per word as it leaves the FIFO.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= (^w_head) ^ c_PAR_INV;
    end
  end
`endif

  // Line level for the current state; registered below so UART_TX is glitch
  // free and busy/done stay aligned with it.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_line = r_parity;
`endif
      default:  w_line = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx   <= w_line;
      r_busy <= (r_state != S_IDLE);
      r_done <= w_last_stop;
      if (w_pop) begin
        r_shift <= w_head;
        r_baud  <= c_BAUD_RELOAD;
        r_state <= S_START;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_bit_idx <= '0;
          end
          S_START: begin
            if (w_bit_end) begin
              r_baud    <= c_BAUD_RELOAD;
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end else begin
              r_baud <= r_baud - 1'b1;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_baud  <= c_BAUD_RELOAD;
              r_shift <= r_shift >> 1;
              if (r_bit_idx == c_LAST_DATA) begin
                r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_state   <= S_PARITY;
`else
                r_state   <= S_STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_baud <= r_baud - 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (w_bit_end) begin
              r_baud    <= c_BAUD_RELOAD;
              r_bit_idx <= '0;
              r_state   <= S_STOP;
            end else begin
              r_baud <= r_baud - 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (w_bit_end) begin
              if (r_bit_idx == c_LAST_STOP) begin
                r_state <= S_IDLE;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_baud    <= c_BAUD_RELOAD;
              end
            end else begin
              r_baud <= r_baud - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo. Instance A is
//            8 data bits / 1 stop bit / depth 4; instance B is 7 data bits /
//            2 stop bits. Both run at 4 clocks per bit. Frame bit patterns
//            are hand-computed (bit 0 = start bit) for both parity builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       sysclk = 1'b0;
  logic       reset;

  logic [7:0] data_a;
  logic       valid_a, ready_a, en_a, busy_a, done_a, tx_a;
  logic [2:0] cnt_a;

  logic [6:0] data_b;
  logic       valid_b, ready_b, en_b, busy_b, done_b, tx_b;
  logic [2:0] cnt_b;

  int errors = 0;
  int checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam int          NB8  = 11;
  localparam int          NB7  = 11;
  localparam logic [15:0] F_A5 = 16'h054A;
  localparam logic [15:0] F_07 = 16'h060E;
  localparam logic [15:0] F_11 = 16'h0422;
  localparam logic [15:0] F_22 = 16'h0444;
  localparam logic [15:0] F_33 = 16'h0466;
  localparam logic [15:0] F_44 = 16'h0488;
  localparam logic [15:0] F_41 = 16'h0682;
`else
  localparam int          NB8  = 10;
  localparam int          NB7  = 10;
  localparam logic [15:0] F_A5 = 16'h034A;
  localparam logic [15:0] F_07 = 16'h020E;
  localparam logic [15:0] F_11 = 16'h0222;
  localparam logic [15:0] F_22 = 16'h0244;
  localparam logic [15:0] F_33 = 16'h0266;
  localparam logic [15:0] F_44 = 16'h0288;
  localparam logic [15:0] F_41 = 16'h0382;
`endif

  always #5 sysclk = ~sysclk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) u_dut_a (
    .sysclk(sysclk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .enable(en_a), .fifo_count(cnt_a), .busy(busy_a),
    .done(done_a), .UART_TX(tx_a)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) u_dut_b (
    .sysclk(sysclk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .enable(en_b), .fifo_count(cnt_b), .busy(busy_b),
    .done(done_b), .UART_TX(tx_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench on the negedge of the first start-bit cycle.
  task automatic wait_start(input bit use_b, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if ((use_b ? tx_b : tx_a) == 1'b0) found = 1'b1;
      else @(negedge sysclk);
    end
    if (!found) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Samples one whole frame starting at its first cycle; ends on the negedge
  // of the cycle right after the frame.
  task automatic capture(input bit use_b, input int nb, input logic [15:0] bits,
                         input string tag);
    logic [63:0] dv;
    logic [63:0] bv;
    logic [3:0]  seg;
    dv = '0;
    bv = '0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        seg[c]       = use_b ? tx_b : tx_a;
        dv[b*4 + c]  = use_b ? done_b : done_a;
        bv[b*4 + c]  = use_b ? busy_b : busy_a;
        @(negedge sysclk);
      end
      check($sformatf("%s_bit%0d", tag, b), 64'(seg), bits[b] ? 64'hF : 64'h0);
    end
    check({tag, "_done"}, dv, 64'd1 << (nb*4 - 1));
    check({tag, "_busy"}, bv, (64'd1 << (nb*4)) - 64'd1);
  endtask

  // Collects the line over n cycles (n <= 32) into the low bits.
  task automatic idle_line(input int n, output logic [63:0] txv, output logic [63:0] bsv);
    txv = '0;
    bsv = '0;
    for (int i = 0; i < n; i++) begin
      txv[i] = tx_a;
      bsv[i] = busy_a;
      @(negedge sysclk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] txv, bsv;
    logic [7:0]  words [5];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;

    reset = 1'b1;
    data_a = '0; valid_a = 1'b0; en_a = 1'b1;
    data_b = '0; valid_b = 1'b0; en_b = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;

    // Reset state
    check("rst_tx",    64'(tx_a),    64'd1);
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    check("rst_count", 64'(cnt_a),   64'd0);
    check("rst_tx_b",  64'(tx_b),    64'd1);

    // Latency, same-cycle push/pop, back-to-back frames: 0xA5 then 0x07
    valid_a = 1'b1; data_a = 8'hA5;
    @(negedge sysclk);
    check("lat_count1", 64'(cnt_a), 64'd1);
    check("lat_tx_n",   64'(tx_a),  64'd1);
    data_a = 8'h07;
    @(negedge sysclk);
    valid_a = 1'b0;
    check("pushpop_count", 64'(cnt_a),  64'd1);
    check("lat_tx_n1",     64'(tx_a),   64'd1);
    check("lat_busy_n1",   64'(busy_a), 64'd0);
    @(negedge sysclk);
    check("lat_tx_n2", 64'(tx_a), 64'd0);
    capture(1'b0, NB8, F_A5, "fA5");
    capture(1'b0, NB8, F_07, "f07");
    check("b2b_end_tx",    64'(tx_a),   64'd1);
    check("b2b_end_busy",  64'(busy_a), 64'd0);
    check("b2b_end_count", 64'(cnt_a),  64'd0);

    // Fill with enable low: fifth word dropped
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_a = 1'b1;
      data_a  = words[i];
      @(negedge sysclk);
    end
    valid_a = 1'b0;
    check("full_count", 64'(cnt_a),   64'd4);
    check("full_ready", 64'(ready_a), 64'd0);
    check("full_tx",    64'(tx_a),    64'd1);
    check("full_busy",  64'(busy_a),  64'd0);
    en_a = 1'b1;
    wait_start(1'b0, "fill");
    capture(1'b0, NB8, F_11, "q11");
    capture(1'b0, NB8, F_22, "q22");
    capture(1'b0, NB8, F_33, "q33");
    capture(1'b0, NB8, F_44, "q44");
    idle_line(20, txv, bsv);
    check("drop_tx_idle",   txv, 64'hFFFFF);
    check("drop_busy_idle", bsv, 64'h0);
    check("drop_count",     64'(cnt_a), 64'd0);

    // Enable dropped mid-frame with two words queued
    for (int i = 1; i < 4; i++) begin
      valid_a = 1'b1;
      data_a  = words[i];
      @(negedge sysclk);
    end
    valid_a = 1'b0;
    wait_start(1'b0, "endrop");
    en_a = 1'b0;
    capture(1'b0, NB8, F_22, "en22");
    idle_line(20, txv, bsv);
    check("endis_tx_idle", txv, 64'hFFFFF);
    check("endis_busy",    bsv, 64'h0);
    check("endis_count",   64'(cnt_a), 64'd2);

    // Reset during a data bit, then a fresh frame
    en_a = 1'b1;
    wait_start(1'b0, "rstmid");
    repeat (10) @(negedge sysclk);
    check("rstmid_busy_before", 64'(busy_a), 64'd1);
    reset = 1'b1;
    @(negedge sysclk);
    check("rstmid_tx",    64'(tx_a),    64'd1);
    check("rstmid_count", 64'(cnt_a),   64'd0);
    check("rstmid_busy",  64'(busy_a),  64'd0);
    check("rstmid_done",  64'(done_a),  64'd0);
    check("rstmid_ready", 64'(ready_a), 64'd1);
    reset = 1'b0;
    idle_line(16, txv, bsv);
    check("rstmid_tx_idle", txv, 64'hFFFF);
    valid_a = 1'b1; data_a = 8'hA5;
    @(negedge sysclk);
    valid_a = 1'b0;
    wait_start(1'b0, "rstnew");
    capture(1'b0, NB8, F_A5, "rA5");

    // Instance B: 7 data bits, 2 stop bits, 0x41
    valid_b = 1'b1; data_b = 7'h41;
    @(negedge sysclk);
    valid_b = 1'b0;
    wait_start(1'b1, "b41");
    capture(1'b1, NB7, F_41, "b41");
    check("b41_end_tx",   64'(tx_b),   64'd1);
    check("b41_end_busy", 64'(busy_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, for host and debug output where the CPU writes bytes faster than the line drains them. It accepts words over a valid/ready handshake, buffers them, and serialises each as start / data (LSB first) / optional parity / stop bits on a standard idle-high line. It is the successor to the fixed 8-bit, unbuffered sender. It adds configurable frame format, an integer baud divider, back-to-back framing and buffer status.

## Interface
Parameters:
- CLKS_PER_BIT, 434, sysclk cycles per bit (≥2); 434 gives 115200 baud at 50 MHz
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- FIFO_DEPTH, 8, FIFO entries, power of two, ≥2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used with UART_TX_PARITY_EN

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- tx_data  in  DATA_BITS  word to transmit
- tx_valid  in  1  tx_data is valid this cycle
- tx_ready  out  1  FIFO can accept a word; equals not-full from registered count
- enable  in  1  permits starting a new frame
- fifo_count  out  log2(FIFO_DEPTH)+1  words currently buffered
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse at the end of each frame
- UART_TX  out  1  serial line, idle high, registered

## Operation
- Push: tx_valid && tx_ready writes tx_data at the tail. Words offered while tx_ready=0 are dropped; upstream must hold them.
- FSM states are IDLE, START, DATA, PARITY, STOP. A baud counter reloads to CLKS_PER_BIT-1 on each bit entry and counts down; a bit ends when the count reaches 0.
- IDLE: if enable=1 and the FIFO is not empty, pop the head into the shift register and go to START.
- START drives UART_TX=0. DATA shifts out DATA_BITS bits, LSB first. PARITY is present only when compiled in. STOP drives UART_TX=1 for STOP_BITS bit times.
- End of the last stop bit:
  - If enable=1 and the FIFO is non-empty, pop and go directly to START with no idle gap.
  - Otherwise go to IDLE.
- enable=0 only blocks new frames. A frame already in progress always completes.
- Same cycle push and pop: fifo_count is unchanged, and pointers wrap modulo FIFO_DEPTH.
- Full FIFO with a pop in the same cycle: tx_ready is still 0 that cycle, so there is no combinational ready path.
- Empty FIFO with a push in the same cycle: the new word is not popped that cycle. It is popped on the next cycle.
- Reset, including mid-frame:
  - FIFO flushed, fifo_count=0, FSM in IDLE.
  - UART_TX=1, busy=0, done=0, tx_ready=1 from the cycle after the reset edge.

## Timing
- Latency: a word pushed into an empty FIFO at edge N, in IDLE with enable=1, gets its pop at edge N+1. UART_TX falls after edge N+2.
- Each bit lasts exactly CLKS_PER_BIT cycles. There is no jitter or fractional divide.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 if parity is compiled in, else 0.
- busy is high from the first START cycle through the last STOP cycle. It stays high continuously across back-to-back frames.
- done is high for exactly the last cycle of the final stop bit.
- tx_ready and fifo_count update one cycle after the push or pop edge.

## Configuration
- UART_TX_PARITY_EN defined:
  - A PARITY bit is inserted after the data bits.
  - Its value is the XOR of the data bits, inverted when PARITY_ODD=1.
- UART_TX_PARITY_EN not defined:
  - There is no PARITY state, and DATA goes directly to STOP.
  - PARITY_ODD is ignored.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, no parity, push 0xA5: UART_TX reads 0,1,0,1,0,0,1,0,1 then 1. Each bit holds 4 cycles, and done pulses at cycle 40 of the frame.
- With UART_TX_PARITY_EN, even parity, push 0xA5 then 0x07: parity bits are 0 then 1. Frames are 44 cycles each, with no idle gap between them and busy held high throughout.
- FIFO_DEPTH=4, enable=0, push 5 words: the first 4 are accepted, fifo_count=4, tx_ready=0 and the fifth is dropped. Raising enable transmits the 4 words in order.
- Drop enable mid-frame with 2 words queued: the current frame completes, UART_TX stays at 1 afterwards and fifo_count=2.
- Assert reset during a DATA bit: UART_TX=1, fifo_count=0, busy=0 and tx_ready=1 next cycle. A fresh push then transmits correctly.
- DATA_BITS=7, STOP_BITS=2, push 0x41: the frame is 10 bit times, and the two stop bits are high for 8 cycles with CLKS_PER_BIT=4.
